io_uart_tx: RTL and testbench

- Consumer end of the CPU output port: captures each io_write/io_data event from the core.
- Buffers each captured 64-bit word in a FIFO.
- Serializes each word as 8 UART frames (8N1) on a single tx line.
- Sits beside the cpu at top level and turns the core's memory-mapped output (stores to RAM address 0xFF) into a host-visible serial stream.

---
 rtl/io_uart_tx.sv | 199 +++++++++++++++++++
 tb/tb_io_uart_tx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_uart_tx.sv
// io_uart_tx
//   Consumer end of the CPU output port. Every io_write strobe captures a
//   64-bit word into a small FIFO; a transmit FSM pops words one at a time and
//   sends each one as eight 8N1 UART frames, least-significant byte first.
//
// Ports
//   clk        : system clock, all logic on the rising edge
//   rst        : synchronous active-high reset
//   io_write   : single-cycle strobe, io_data is valid this cycle
//   io_data    : 64-bit word to transmit
//   tx         : UART serial line, idles high
//   busy       : high while the transmit FSM is not idle
//   fifo_count : words waiting in the FIFO (the word being shifted is excluded)
//   overflow   : sticky flag, a write was dropped because the FIFO was full
module io_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH        = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         io_write,
    input  logic [63:0]                  io_data,
    output logic                         tx,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         overflow
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [63:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;

    state_e state_q;
    state_e state_d;

    logic full;
    logic pop;
    logic push;
    logic drop;

    // The pop decision uses the pre-edge count, so a word pushed into an
    // empty FIFO cannot be popped on the same edge.
    assign pop  = (state_q == S_IDLE) && (count_q != '0);
    assign full = (count_q == CNT_W'(DEPTH));
    // A pop on the same edge frees a slot, so a write at full is still taken.
    assign push = io_write && (!full || pop);
    assign drop = io_write && full && !pop;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (drop) overflow_q <= 1'b1;
        end
    end

    // NOTE: the storage array has no reset; emptiness is tracked by the
    // pointers and count, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= io_data;
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    logic [BAUD_W-1:0] baud_q,  baud_d;
    logic [2:0]        bit_q,   bit_d;
    logic [2:0]        byte_q,  byte_d;
    logic [63:0]       shift_q, shift_d;
    logic              tx_q,    tx_d;
    logic              baud_done;
    logic [7:0]        cur_byte;

    assign baud_done = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign cur_byte  = shift_q[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // tx is registered: each branch loads the level the line must carry
    // from the next edge onwards.
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        tx_d    = tx_q;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (pop) begin
                    shift_d = mem_q[rd_ptr_q];
                    byte_d  = '0;
                    baud_d  = '0;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = cur_byte[0];
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = cur_byte[bit_d];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (byte_q != 3'd7) begin
                        // Next byte starts immediately, no idle gap.
                        byte_d  = byte_q + 3'd1;
                        shift_d = shift_q >> 8;
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE);
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_io_uart_tx.sv
// tb_io_uart_tx
//   Directed bench for io_uart_tx with CLKS_PER_BIT=4 and DEPTH=4. Expected
//   bytes are queued when words are written; a UART receiver on the tx line
//   decodes frames and compares each byte against the head of the queue.
module tb_io_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int HALF  = CPB / 2;

    logic                       clk;
    logic                       rst;
    logic                       io_write;
    logic [63:0]                io_data;
    logic                       tx;
    logic                       busy;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;
    logic                       overflow;

    int errors = 0;
    int checks = 0;

    logic [7:0] rx_q [$];
    bit         mon_en   = 1'b0;
    bit         rx_flush = 1'b0;
    bit         rx_active = 1'b0;
    int         rx_tick;
    logic [7:0] rx_byte;

    io_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .io_write   (io_write),
        .io_data    (io_data),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge, after the DUT edge.
    task automatic drive_cycle(input logic w, input logic [63:0] d);
        io_write = w;
        io_data  = d;
        @(negedge clk);
        io_write = 1'b0;
    endtask

    task automatic expect_bytes(input logic [63:0] w, input int nbytes);
        for (int i = 0; i < nbytes; i++) rx_q.push_back(w[8*i +: 8]);
    endtask

    task automatic wait_not_busy(input string tag, input int limit, output int n);
        n = 0;
        while (busy === 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, {63'd0, busy}, 64'd0);
    endtask

    task automatic wait_drained(input string tag, input int limit);
        int n = 0;
        while ((busy !== 1'b0 || fifo_count !== '0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, {63'd0, busy}, 64'd0);
        // Let the receiver finish the trailing stop bit.
        repeat (2 * CPB) @(negedge clk);
        check({tag, "_queue_empty"}, 64'(rx_q.size()), 64'd0);
    endtask

    task automatic reset_pulse();
        rst      = 1'b1;
        rx_flush = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // UART receiver: start detected at the first low negedge sample, then
    // each bit is sampled near its centre.
    always @(negedge clk) begin
        if (rx_flush || rst || !mon_en) begin
            rx_active = 1'b0;
            rx_flush  = 1'b0;
        end else if (!rx_active) begin
            if (tx === 1'b0) begin
                rx_active = 1'b1;
                rx_tick   = 0;
                rx_byte   = '0;
            end
        end else begin
            rx_tick++;
            if (rx_tick == HALF - 1) begin
                check("rx_start_bit", {63'd0, tx}, 64'd0);
            end else if (rx_tick >= CPB + HALF - 1 && rx_tick <= 8*CPB + HALF - 1
                         && ((rx_tick - (HALF - 1)) % CPB) == 0) begin
                rx_byte[(rx_tick - (HALF - 1)) / CPB - 1] = tx;
            end else if (rx_tick == 9*CPB + HALF - 1) begin
                check("rx_stop_bit", {63'd0, tx}, 64'd1);
                if (rx_q.size() == 0) begin
                    check("rx_unexpected_byte", {56'd0, rx_byte}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check("rx_byte", {56'd0, rx_byte}, {56'd0, rx_q.pop_front()});
                end
                rx_active = 1'b0;
            end
        end
    end

    initial begin
        int n;
        int exp_cnt [6] = '{1, 1, 2, 3, 4, 4};
        int exp_ovf [6] = '{0, 0, 0, 0, 0, 1};

        rst      = 1'b1;
        io_write = 1'b0;
        io_data  = '0;
        repeat (3) @(negedge clk);
        check("reset_tx",       {63'd0, tx},       64'd1);
        check("reset_busy",     {63'd0, busy},     64'd0);
        check("reset_count",    64'(fifo_count),   64'd0);
        check("reset_overflow", {63'd0, overflow}, 64'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Single word: latency, byte order, busy duration.
        expect_bytes(64'h0123_4567_89AB_CDEF, 8);
        drive_cycle(1'b1, 64'h0123_4567_89AB_CDEF);
        check("single_push_count", 64'(fifo_count), 64'd1);
        check("single_push_tx",    {63'd0, tx},     64'd1);
        check("single_push_busy",  {63'd0, busy},   64'd0);
        drive_cycle(1'b0, $urandom());
        check("single_pop_tx",    {63'd0, tx},     64'd0);
        check("single_pop_busy",  {63'd0, busy},   64'd1);
        check("single_pop_count", 64'(fifo_count), 64'd0);
        wait_not_busy("single_busy_end", 1000, n);
        check("single_busy_cycles", 64'(n), 64'd320);
        check("single_tx_after",    {63'd0, tx}, 64'd1);
        wait_drained("single_drain", 1000);

        // Back-to-back words with one idle cycle between them.
        expect_bytes(64'h11, 8);
        expect_bytes(64'h22, 8);
        drive_cycle(1'b1, 64'h11);
        check("b2b_count_1", 64'(fifo_count), 64'd1);
        drive_cycle(1'b1, 64'h22);
        check("b2b_count_2", 64'(fifo_count), 64'd1);
        check("b2b_busy_2",  {63'd0, busy},   64'd1);
        drive_cycle(1'b0, '0);
        check("b2b_count_3", 64'(fifo_count), 64'd1);
        wait_not_busy("b2b_word1_end", 1000, n);
        check("b2b_gap_tx",    {63'd0, tx},     64'd1);
        check("b2b_gap_count", 64'(fifo_count), 64'd1);
        drive_cycle(1'b0, '0);
        check("b2b_pop2_busy",  {63'd0, busy},   64'd1);
        check("b2b_pop2_tx",    {63'd0, tx},     64'd0);
        check("b2b_pop2_count", 64'(fifo_count), 64'd0);
        wait_drained("b2b_drain", 1000);

        // Overflow: six writes while idle, the sixth is dropped.
        for (int i = 0; i < 6; i++) begin
            if (i < 5) expect_bytes(64'(i + 1), 8);
            drive_cycle(1'b1, 64'(i + 1));
            check($sformatf("ovf_count_%0d", i + 1),    64'(fifo_count), 64'(exp_cnt[i]));
            check($sformatf("ovf_overflow_%0d", i + 1), {63'd0, overflow}, 64'(exp_ovf[i]));
        end
        wait_drained("ovf_drain", 3000);
        check("ovf_sticky", {63'd0, overflow}, 64'd1);
        reset_pulse();
        check("ovf_cleared", {63'd0, overflow}, 64'd0);

        // Full FIFO with a write on the popping edge.
        for (int i = 0; i < 5; i++) begin
            expect_bytes(64'hF0 + 64'(i), 8);
            drive_cycle(1'b1, 64'hF0 + 64'(i));
        end
        check("fullpop_full_count", 64'(fifo_count), 64'd4);
        wait_not_busy("fullpop_word1_end", 1000, n);
        check("fullpop_idle_count", 64'(fifo_count), 64'd4);
        expect_bytes(64'hF5, 8);
        drive_cycle(1'b1, 64'hF5);
        check("fullpop_count",    64'(fifo_count), 64'd4);
        check("fullpop_overflow", {63'd0, overflow}, 64'd0);
        check("fullpop_busy",     {63'd0, busy},   64'd1);
        wait_drained("fullpop_drain", 3000);
        check("fullpop_overflow_end", {63'd0, overflow}, 64'd0);

        // Reset during DATA of byte 3; the queued second word is discarded.
        expect_bytes(64'h1122_3344_5566_7788, 3);
        drive_cycle(1'b1, 64'h1122_3344_5566_7788);
        drive_cycle(1'b1, 64'hDEAD_BEEF_DEAD_BEEF);
        check("rstmid_count", 64'(fifo_count), 64'd1);
        repeat (130) @(negedge clk);
        check("rstmid_busy_before", {63'd0, busy}, 64'd1);
        reset_pulse();
        check("rstmid_tx",       {63'd0, tx},       64'd1);
        check("rstmid_busy",     {63'd0, busy},     64'd0);
        check("rstmid_count",    64'(fifo_count),   64'd0);
        check("rstmid_overflow", {63'd0, overflow}, 64'd0);
        check("rstmid_partial_bytes", 64'(rx_q.size()), 64'd0);
        expect_bytes(64'hA5, 8);
        drive_cycle(1'b1, 64'hA5);
        wait_drained("rstmid_a5_drain", 1000);

        // Idle hold: io_data toggles with io_write low.
        for (int i = 0; i < 1000; i++) begin
            drive_cycle(1'b0, {$urandom(), $urandom()});
            check("idle_tx",    {63'd0, tx},     64'd1);
            check("idle_busy",  {63'd0, busy},   64'd0);
            check("idle_count", 64'(fifo_count), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
